// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU, load) register-file write arbiter with one holding entry per source.
// Optional build macro RFARB_ZERO_DROP_EN: accepted writes to register 0 are silently dropped.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        aluValid,
  input  logic [4:0]  aluAddr,
  input  logic [31:0] aluData,
  output logic        aluReady,
  input  logic        memValid,
  input  logic [4:0]  memAddr,
  input  logic [31:0] memData,
  output logic        memReady,
  output logic        writeEnable,
  output logic [4:0]  writeAddr,
  output logic [31:0] writeData,
  output logic        busy,
  output logic [7:0]  stallCount
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] STALL_MAX = '1;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        ha_q, ha_d, hm_q, hm_d;
  src_e          last_grant_q, last_grant_d;
  logic          mem_older_q, mem_older_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] stall_q, stall_d;

  logic grant_a_c, grant_m_c;
  logic accept_a_c, accept_m_c;
  logic load_a_c, load_m_c;

  // Grant: single full entry wins; same-address pair goes to the older; else round-robin.
  always_comb begin
    grant_a_c = 1'b0;
    grant_m_c = 1'b0;
    if (ha_q.full && hm_q.full) begin
      if (ha_q.addr == hm_q.addr) begin
        if (mem_older_q) grant_m_c = 1'b1;
        else             grant_a_c = 1'b1;
      end else if (last_grant_q == SRC_MEM) begin
        grant_a_c = 1'b1;
      end else begin
        grant_m_c = 1'b1;
      end
    end else begin
      grant_a_c = ha_q.full;
      grant_m_c = hm_q.full;
    end
  end

  assign aluReady   = ~rst & (~ha_q.full | grant_a_c);
  assign memReady   = ~rst & (~hm_q.full | grant_m_c);
  assign accept_a_c = aluValid & aluReady;
  assign accept_m_c = memValid & memReady;

`ifdef RFARB_ZERO_DROP_EN
  assign load_a_c = accept_a_c & (aluAddr != '0);
  assign load_m_c = accept_m_c & (memAddr != '0);
`else
  assign load_a_c = accept_a_c;
  assign load_m_c = accept_m_c;
`endif

  always_comb begin
    ha_d         = ha_q;
    hm_d         = hm_q;
    last_grant_d = last_grant_q;
    mem_older_d  = mem_older_q;
    we_d         = grant_a_c | grant_m_c;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    stall_d      = stall_q;

    if (grant_a_c) begin
      ha_d.full    = 1'b0;
      waddr_d      = ha_q.addr;
      wdata_d      = ha_q.data;
      last_grant_d = SRC_ALU;
    end else if (grant_m_c) begin
      hm_d.full    = 1'b0;
      waddr_d      = hm_q.addr;
      wdata_d      = hm_q.data;
      last_grant_d = SRC_MEM;
    end

    if (load_a_c) ha_d = '{full: 1'b1, addr: aluAddr, data: aluData};
    if (load_m_c) hm_d = '{full: 1'b1, addr: memAddr, data: memData};

    // The entry loaded later is the younger; a simultaneous load makes MEM the older.
    if (load_a_c)      mem_older_d = 1'b1;
    else if (load_m_c) mem_older_d = 1'b0;

    // Both full means exactly one is left waiting this edge.
    if (ha_q.full && hm_q.full && (stall_q != STALL_MAX))
      stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ha_q         <= '0;
      hm_q         <= '0;
      last_grant_q <= SRC_MEM;
      mem_older_q  <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      stall_q      <= '0;
    end else begin
      ha_q         <= ha_d;
      hm_q         <= hm_d;
      last_grant_q <= last_grant_d;
      mem_older_q  <= mem_older_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      stall_q      <= stall_d;
    end
  end

  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;
  assign busy        = ha_q.full | hm_q.full;
  assign stallCount  = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid, memValid;
  logic [4:0]  aluAddr, memAddr;
  logic [31:0] aluData, memData;
  logic        aluReady, memReady;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        busy;
  logic [7:0]  stallCount;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .busy(busy), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(writeEnable), 32'd1);
    chk({tag, "_addr"}, 32'(writeAddr), 32'(a));
    chk({tag, "_data"}, writeData, d);
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    aluValid = v; aluAddr = a; aluData = d;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    memValid = v; memAddr = a; memData = d;
  endtask

  initial begin
    rst = 1'b1;
    drive_alu(1'b1, 5'd1, 32'hdead);
    drive_mem(1'b1, 5'd2, 32'hbeef);
    #1;
    chk("rst_alu_ready", 32'(aluReady), 32'd0);
    chk("rst_mem_ready", 32'(memReady), 32'd0);
    tick(); tick();
    chk("rst_we", 32'(writeEnable), 32'd0);
    chk("rst_waddr", 32'(writeAddr), 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stallCount), 32'd0);
    chk("rst_alu_ready_hold", 32'(aluReady), 32'd0);

    // Release reset with nothing requested.
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    tick();
    chk("post_rst_we", 32'(writeEnable), 32'd0);
    chk("post_rst_alu_ready", 32'(aluReady), 32'd1);

    // Uncontended ALU write: one-edge latency.
    drive_alu(1'b1, 5'd3, 32'd10);
    tick();
    chk("unc_busy", 32'(busy), 32'd1);
    chk("unc_we_early", 32'(writeEnable), 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("unc_wr", 5'd3, 32'd10);
    chk("unc_busy_clr", 32'(busy), 32'd0);
    tick();
    chk("unc_we_off", 32'(writeEnable), 32'd0);
    chk("unc_addr_hold", 32'(writeAddr), 32'd3);
    chk("unc_data_hold", writeData, 32'd10);

    // Different-address contention directly after reset: ALU wins first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_alu(1'b1, 5'd1, 32'd16);
    drive_mem(1'b1, 5'd2, 32'd22);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_we", 32'(writeEnable), 32'd0);
    chk("c1_alu_ready", 32'(aluReady), 32'd1);
    chk("c1_mem_ready", 32'(memReady), 32'd0);
    tick();
    chk_wr("c1_first", 5'd1, 32'd16);
    chk("c1_stall", 32'(stallCount), 32'd1);
    chk("c1_busy2", 32'(busy), 32'd1);
    tick();
    chk_wr("c1_second", 5'd2, 32'd22);
    chk("c1_busy3", 32'(busy), 32'd0);
    chk("c1_stall2", 32'(stallCount), 32'd1);
    tick();
    chk("c1_we_off", 32'(writeEnable), 32'd0);

    // Round-robin with lastGrant=ALU: MEM wins the next different-address contention.
    drive_alu(1'b1, 5'd7, 32'h70);
    tick();
    chk("rr_we0", 32'(writeEnable), 32'd0);
    drive_alu(1'b1, 5'd9, 32'h90);
    drive_mem(1'b1, 5'd10, 32'ha0);
    chk("rr_alu_ready_drain", 32'(aluReady), 32'd1);
    chk("rr_mem_ready", 32'(memReady), 32'd1);
    tick();
    chk_wr("rr_w7", 5'd7, 32'h70);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("rr_mem_first", 5'd10, 32'ha0);
    chk("rr_stall", 32'(stallCount), 32'd2);
    tick();
    chk_wr("rr_alu_second", 5'd9, 32'h90);
    tick();
    chk("rr_we_off", 32'(writeEnable), 32'd0);

    // Same address: MEM is older and wins even though lastGrant=MEM.
    drive_mem(1'b1, 5'd11, 32'hb0);
    tick();
    drive_alu(1'b1, 5'd5, 32'd7);
    drive_mem(1'b1, 5'd5, 32'd9);
    chk("sa_mem_ready", 32'(memReady), 32'd1);
    tick();
    chk_wr("sa_w11", 5'd11, 32'hb0);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("sa_older_mem", 5'd5, 32'd9);
    chk("sa_stall", 32'(stallCount), 32'd3);
    tick();
    chk_wr("sa_younger_alu", 5'd5, 32'd7);
    tick();
    chk("sa_we_off", 32'(writeEnable), 32'd0);

    // MEM streaming, one write per cycle.
    for (int i = 0; i < 4; i++) begin
      drive_mem(1'b1, 5'd8, 32'(i + 1));
      chk("st_mem_ready", 32'(memReady), 32'd1);
      tick();
      if (i == 0) chk("st_we0", 32'(writeEnable), 32'd0);
      else        chk_wr("st_wr", 5'd8, 32'(i));
    end
    drive_mem(1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("st_last", 5'd8, 32'd4);
    tick();
    chk("st_we_off", 32'(writeEnable), 32'd0);

    // Continuous contention saturates the stall counter.
    drive_alu(1'b1, 5'd20, 32'h111);
    drive_mem(1'b1, 5'd21, 32'h222);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_stall", 32'(stallCount), 32'd255);
    chk("sat_busy", 32'(busy), 32'd1);

    // Reset mid-contention discards both entries.
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_we", 32'(writeEnable), 32'd0);
    chk("mr_stall", 32'(stallCount), 32'd0);
    rst = 1'b0;
    tick();
    chk("mr_we_after1", 32'(writeEnable), 32'd0);
    tick();
    chk("mr_we_after2", 32'(writeEnable), 32'd0);

    // Zero destination register.
    drive_alu(1'b1, 5'd0, 32'hffff);
    chk("z_alu_ready", 32'(aluReady), 32'd1);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();
`ifdef RFARB_ZERO_DROP_EN
    chk("z_dropped_we", 32'(writeEnable), 32'd0);
    chk("z_dropped_busy", 32'(busy), 32'd0);
`else
    chk_wr("z_written", 5'd0, 32'hffff);
`endif
    tick();
    chk("z_we_off", 32'(writeEnable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
